// File: rtl/ack_bus_scheduler_pkg.sv
// Shared definitions for the ACK bus scheduler and its helpers.
// Source IDs, source count and the scheduler state encoding.
package ack_bus_pkg;

  localparam int NUM_SRC = 4;

  localparam logic [1:0] ID_MEM  = 2'd0;
  localparam logic [1:0] ID_SHA  = 2'd1;
  localparam logic [1:0] ID_AES  = 2'd2;
  localparam logic [1:0] ID_CTRL = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } sched_state_t;

  // One-hot grant vector for a source ID.
  function automatic logic [NUM_SRC-1:0] id_to_onehot(input logic [1:0] id);
    logic [NUM_SRC-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/ack_bus_scheduler_if.sv
// ACK bus scheduler interface: request/done inputs from the sources,
// grant/status outputs from the scheduler.
// Optional macro ACK_SCHED_TIMEOUT_EN adds the sticky timeout_err signal.
interface ack_bus_scheduler_if;
  import ack_bus_pkg::*;

  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] done;
  logic [NUM_SRC-1:0] grant;
  logic               grant_valid;
  logic [1:0]         grant_id;
  logic               ack_event;
  logic               busy;
`ifdef ACK_SCHED_TIMEOUT_EN
  logic               timeout_err;
`endif

  // Scheduler side.
  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_valid,
    output grant_id,
    output ack_event,
`ifdef ACK_SCHED_TIMEOUT_EN
    output timeout_err,
`endif
    output busy
  );

  // Source / listener side.
  modport master (
    output req,
    output done,
    input  grant,
    input  grant_valid,
    input  grant_id,
    input  ack_event,
`ifdef ACK_SCHED_TIMEOUT_EN
    input  timeout_err,
`endif
    input  busy
  );

endinterface

// File: rtl/ack_bus_scheduler_rr_pick4.sv
// Combinational rotating-priority picker for four requesters.
// Scans from (last+1) mod 4 upward with wrap-around; the source that won
// last time therefore has the lowest priority.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       any,
  output logic [1:0] winner
);

  // First set request bit after the previous winner, wrapping.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    any    = |req;
    winner = last;
    found  = 1'b0;
    idx    = last;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (req[idx] && !found) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ack_bus_scheduler.sv
// Registered round-robin scheduler for the shared open-drain ACK bus.
// A grant is held until the grantee signals done or drops its request,
// followed by GAP_CYCLES idle turnaround cycles before the next pick.
// Optional macro ACK_SCHED_TIMEOUT_EN: forced release after TIMEOUT_CYCLES
// grant cycles and a sticky timeout_err flag.
module ack_bus_scheduler
  import ack_bus_pkg::*;
#(
  parameter int GAP_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int CNT_W          = 8
) (
  input logic                clk,
  input logic                rst,
  ack_bus_scheduler_if.slave bus
);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  // Counter width must cover both configured cycle counts.
  if (!((2 ** CNT_W) > GAP_CYCLES && (2 ** CNT_W) > TIMEOUT_CYCLES)) begin : g_cnt_w_check
    $error("CNT_W too small for GAP_CYCLES/TIMEOUT_CYCLES");
  end

  sched_state_t       state, state_nxt;
  logic [NUM_SRC-1:0] grant, grant_nxt;
  logic [1:0]         grant_id, grant_id_nxt;   // doubles as the round-robin pointer
  logic               ack_event, ack_event_nxt;
  logic [CNT_W-1:0]   gap_cnt, gap_cnt_nxt;
  logic               pick_any;
  logic [1:0]         pick_id;
  logic               release_req;
`ifdef ACK_SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  logic [CNT_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic               timeout_err, timeout_err_nxt;
  logic               hold_expired;
`endif

  rr_pick4 u_pick (
    .req    (bus.req),
    .last   (grant_id),
    .any    (pick_any),
    .winner (pick_id)
  );

  // Next-state and next-output logic for the IDLE/GRANT/GAP sequence.
  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    grant_id_nxt  = grant_id;
    ack_event_nxt = 1'b0;
    gap_cnt_nxt   = gap_cnt;
    // Only the current grantee's done/req are looked at.
    release_req   = bus.done[grant_id] || !bus.req[grant_id];
`ifdef ACK_SCHED_TIMEOUT_EN
    hold_cnt_nxt    = hold_cnt;
    timeout_err_nxt = timeout_err;
    hold_expired    = (hold_cnt == HOLD_LAST);
`endif
    case (state)
      IDLE: begin
        if (pick_any) begin
          grant_nxt     = id_to_onehot(pick_id);
          grant_id_nxt  = pick_id;
          ack_event_nxt = 1'b1;
          state_nxt     = GRANT;
`ifdef ACK_SCHED_TIMEOUT_EN
          hold_cnt_nxt  = '0;
`endif
        end
      end
      GRANT: begin
`ifdef ACK_SCHED_TIMEOUT_EN
        hold_cnt_nxt = hold_cnt + 1'b1;
        if (hold_expired && !release_req) begin
          timeout_err_nxt = 1'b1;
        end
        if (release_req || hold_expired) begin
`else
        if (release_req) begin
`endif
          grant_nxt   = '0;
          gap_cnt_nxt = '0;
          state_nxt   = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // State and output registers; reset returns the pointer to CTRL so MEM wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      grant_id  <= ID_CTRL;
      ack_event <= 1'b0;
      gap_cnt   <= '0;
`ifdef ACK_SCHED_TIMEOUT_EN
      hold_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      grant_id  <= grant_id_nxt;
      ack_event <= ack_event_nxt;
      gap_cnt   <= gap_cnt_nxt;
`ifdef ACK_SCHED_TIMEOUT_EN
      hold_cnt    <= hold_cnt_nxt;
      timeout_err <= timeout_err_nxt;
`endif
    end
  end

  assign bus.grant       = grant;
  assign bus.grant_valid = |grant;
  assign bus.grant_id    = grant_id;
  assign bus.ack_event   = ack_event;
  assign bus.busy        = (state == GRANT) || (state == GAP);
`ifdef ACK_SCHED_TIMEOUT_EN
  assign bus.timeout_err = timeout_err;
`endif

endmodule

// File: tb/tb_ack_bus_scheduler.sv
// Directed bench for ack_bus_scheduler (GAP_CYCLES=1, TIMEOUT_CYCLES=8).
// The timeout section is built only when ACK_SCHED_TIMEOUT_EN is defined.
module tb_ack_bus_scheduler;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  ack_bus_scheduler_if bus ();

  ack_bus_scheduler #(
    .GAP_CYCLES     (1),
    .TIMEOUT_CYCLES (8),
    .CNT_W          (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; observe 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] id,
                         input logic ack, input logic bsy);
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
    chk({tag, ".gv"},    32'(bus.grant_valid), 32'(|g));
    chk({tag, ".id"},    32'(bus.grant_id), 32'(id));
    chk({tag, ".ack"},   32'(bus.ack_event), 32'(ack));
    chk({tag, ".busy"},  32'(bus.busy), 32'(bsy));
  endtask

  initial begin
    logic [3:0] exp_g;
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    bus.req  = 4'b0000;
    bus.done = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
    chk_all("reset", 4'b0000, 2'd3, 1'b0, 1'b0);
`ifdef ACK_SCHED_TIMEOUT_EN
    chk("reset.terr", 32'(bus.timeout_err), 32'd0);
`endif

    // Full rotation with all four requesting; each grantee completes at once.
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      tick();
      chk_all($sformatf("rot%0d.grant", k), exp_g, 2'(k % 4), 1'b1, 1'b1);
      bus.done = exp_g;
      tick();
      chk_all($sformatf("rot%0d.gap", k), 4'b0000, 2'(k % 4), 1'b0, 1'b1);
      bus.done = 4'b0000;
      tick();
      chk_all($sformatf("rot%0d.idle", k), 4'b0000, 2'(k % 4), 1'b0, 1'b0);
    end

    // AES alone, held for six cycles.
    bus.req = 4'b0100;
    tick();
    for (int c = 0; c < 6; c++) begin
      chk_all($sformatf("aes.c%0d", c), 4'b0100, 2'd2, (c == 0), 1'b1);
      if (c == 5) begin
        bus.done = 4'b0100;
        bus.req  = 4'b0000;
      end
      tick();
    end
    chk_all("aes.gap", 4'b0000, 2'd2, 1'b0, 1'b1);
    bus.done = 4'b0000;
    tick();
    chk_all("aes.idle", 4'b0000, 2'd2, 1'b0, 1'b0);

    // SHA: foreign done bits ignored, then abandon by dropping req.
    bus.req = 4'b0010;
    tick();
    chk_all("sha.grant", 4'b0010, 2'd1, 1'b1, 1'b1);
    bus.done = 4'b1001;
    tick();
    chk_all("sha.foreign_done", 4'b0010, 2'd1, 1'b0, 1'b1);
    bus.done = 4'b0000;
    tick();
    chk_all("sha.hold", 4'b0010, 2'd1, 1'b0, 1'b1);
    bus.req = 4'b0000;
    tick();
    chk_all("sha.abandon", 4'b0000, 2'd1, 1'b0, 1'b1);
    tick();
    chk_all("sha.idle", 4'b0000, 2'd1, 1'b0, 1'b0);

    // AES wins, then CTRL beats MEM via wrap-around from pointer 2.
    bus.req = 4'b0100;
    tick();
    chk_all("wrap.aes", 4'b0100, 2'd2, 1'b1, 1'b1);
    bus.done = 4'b0100;
    bus.req  = 4'b1001;
    tick();
    chk_all("wrap.gap", 4'b0000, 2'd2, 1'b0, 1'b1);
    bus.done = 4'b0000;
    tick();
    chk_all("wrap.idle", 4'b0000, 2'd2, 1'b0, 1'b0);
    tick();
    chk_all("wrap.ctrl", 4'b1000, 2'd3, 1'b1, 1'b1);
    tick();
    chk_all("wrap.ctrl_hold", 4'b1000, 2'd3, 1'b0, 1'b1);

    // Reset in the middle of the CTRL grant.
    rst = 1'b1;
    tick();
    chk_all("midrst", 4'b0000, 2'd3, 1'b0, 1'b0);
    rst     = 1'b0;
    bus.req = 4'b1010;
    tick();
    chk_all("midrst.sha_first", 4'b0010, 2'd1, 1'b1, 1'b1);
    bus.req = 4'b0000;
    tick();
    chk_all("midrst.release", 4'b0000, 2'd1, 1'b0, 1'b1);
    tick();
    chk_all("midrst.idle", 4'b0000, 2'd1, 1'b0, 1'b0);

`ifdef ACK_SCHED_TIMEOUT_EN
    // MEM holds without done: forced release after 8 grant cycles.
    bus.req = 4'b0001;
    tick();
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("to.c%0d.grant", c), 32'(bus.grant), 32'h1);
      chk($sformatf("to.c%0d.terr", c), 32'(bus.timeout_err), 32'd0);
      tick();
    end
    chk_all("to.release", 4'b0000, 2'd0, 1'b0, 1'b1);
    chk("to.terr_set", 32'(bus.timeout_err), 32'd1);
    bus.req = 4'b0000;
    tick();
    tick();
    chk("to.terr_sticky", 32'(bus.timeout_err), 32'd1);
    chk("to.idle_busy", 32'(bus.busy), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
